// File: rtl/ysyx_25030093_pkg.sv
// Shared definitions for the ysyx_25030093 core: default widths, reset PC and
// the instruction-queue entry layout.
package ysyx_25030093_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

  typedef struct packed {
    logic [XLEN_DEF-1:0] inst;
    logic [XLEN_DEF-1:0] pc;
    logic                err;
  } ifq_entry_t;

endpackage

// File: rtl/ysyx_25030093_ifu_queue_if.sv
// Fetch-unit bus bundle: memory request/response channel, redirect input and
// the instruction handoff towards the IDU.
interface ysyx_25030093_ifu_queue_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_err;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_err;

  modport master (
    output req_valid, req_addr, inst_valid, inst, inst_pc, inst_err,
    input  req_ready, rsp_valid, rsp_data, rsp_err, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  req_valid, req_addr, inst_valid, inst, inst_pc, inst_err,
    output req_ready, rsp_valid, rsp_data, rsp_err, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/ysyx_25030093_sync_fifo.sv
// Small synchronous FIFO with flush and occupancy count; depth need not be a
// power of two. Head data is read combinationally.
module ysyx_25030093_sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  // A full FIFO may still accept when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/ysyx_25030093_ifu_queue.sv
// Queued fetch unit: sequential fetch with bounded outstanding requests, an
// in-order instruction queue and redirect flush. Optional IFQ_BYPASS_EN
// forwards a response straight to the IDU when the queue is empty.
module ysyx_25030093_ifu_queue
  import ysyx_25030093_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input logic                       clk,
  input logic                       rst,
  ysyx_25030093_ifu_queue_if.master bus
);
  localparam int QW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(MAX_OUT + 1);
  localparam int CW = $clog2(DEPTH + MAX_OUT + 1) + 1;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            err;
  } entry_t;

  logic            run;
  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   live, discard;

  logic [QW-1:0]   q_count;
  logic            q_full, q_empty, q_push, q_pop;
  entry_t          q_din, q_head;

  logic [PW-1:0]   pt_count;
  logic            pt_full;
  logic [XLEN-1:0] pt_head;

  logic            accept, rsp_live, rsp_drop, byp;

  // run holds off the first request until the cycle after reset release.
  assign bus.req_valid = run && !bus.redirect_valid
                      && (CW'(q_count) + live < CW'(DEPTH))
                      && (live + discard < CW'(MAX_OUT));
  assign bus.req_addr  = fetch_pc;
  assign accept        = bus.req_valid && bus.req_ready;

  // Responses belonging to flushed requests come back first (in order).
  assign rsp_drop = bus.rsp_valid && (discard != '0);
  assign rsp_live = bus.rsp_valid && (discard == '0);
  assign q_empty  = (q_count == '0);

`ifdef IFQ_BYPASS_EN
  assign byp = rsp_live && q_empty && !bus.redirect_valid;
`else
  assign byp = 1'b0;
`endif

  assign q_din  = '{inst: bus.rsp_data, pc: pt_head, err: bus.rsp_err};
  assign q_push = rsp_live && !bus.redirect_valid && !(byp && bus.inst_ready);
  assign q_pop  = !q_empty && !bus.redirect_valid && bus.inst_ready;

  assign bus.inst_valid = (!q_empty || byp) && !bus.redirect_valid;
  assign bus.inst       = byp ? bus.rsp_data : q_head.inst;
  assign bus.inst_pc    = byp ? pt_head      : q_head.pc;
  assign bus.inst_err   = byp ? bus.rsp_err  : q_head.err;

  ysyx_25030093_sync_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_inst_q (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.redirect_valid),
    .push  (q_push),
    .pop   (q_pop),
    .din   (q_din),
    .dout  (q_head),
    .count (q_count),
    .full  (q_full)
  );

  // PCs of live requests, consumed as their responses arrive.
  ysyx_25030093_sync_fifo #(.W(XLEN), .DEPTH(MAX_OUT)) u_pc_trk (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.redirect_valid),
    .push  (accept),
    .pop   (rsp_live),
    .din   (fetch_pc),
    .dout  (pt_head),
    .count (pt_count),
    .full  (pt_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run      <= 1'b0;
      fetch_pc <= RESET_PC;
      live     <= '0;
      discard  <= '0;
    end else begin
      run <= 1'b1;
      if (bus.redirect_valid) begin
        // Everything in flight becomes discard; a response this cycle retires one.
        live     <= '0;
        discard  <= discard + live + CW'(accept) - CW'(bus.rsp_valid);
        fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      end else begin
        live    <= live + CW'(accept) - CW'(rsp_live);
        discard <= discard - CW'(rsp_drop);
        if (accept) fetch_pc <= fetch_pc + XLEN'(4);
      end
    end
  end

  a_q_no_overflow : assert property (@(posedge clk) disable iff (!rst)
    !(q_push && q_full && !q_pop));
  a_pt_no_overflow : assert property (@(posedge clk) disable iff (!rst)
    !(accept && pt_full));
  a_rsp_has_pc : assert property (@(posedge clk) disable iff (!rst)
    !(rsp_live && pt_count == '0));
endmodule
